countdown_controller: RTL and testbench
=======================================

Name: countdown_controller

Overview:
- Sequences the three BCD digits of the countdown timer: minutes units, tens of seconds and units of seconds (M:SS).
- Loads a user preset, then decrements once per 1 Hz tick while running, with borrow propagation across digits.
- Supports pause and resume, and flags zero-reached for the display and alarm logic.
- Replaces ad-hoc preset/clear wiring of the per-digit flip-flop counters with one registered state machine.

Parameters:
- MIN_MAX, 9, highest legal value of the minutes digit.
- TENS_MAX, 5, highest legal value of the tens-of-seconds digit.
- UNITS_MAX, 9, highest legal value of the units-of-seconds digit.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clear  in  1  synchronous active-low reset.
- tick  in  1  one-cycle enable pulse, 1 Hz.
- load  in  1  copy the preset digits into the counter.
- start  in  1  begin or resume counting.
- pause  in  1  freeze counting.
- preset_min  in  4  minutes digit to load.
- preset_tens  in  4  tens-of-seconds digit to load.
- preset_units  in  4  units-of-seconds digit to load.
- q_min  out  4  current minutes digit.
- q_tens  out  4  current tens-of-seconds digit.
- q_units  out  4  current units-of-seconds digit.
- running  out  1  high in RUN.
- done  out  1  level; high in DONE.
- done_pulse  out  1  one-cycle pulse on entry to DONE.
- state  out  2  encoded FSM state.

Behaviour:
- Reset (clear=0 at a clk edge):
  - state=IDLE.
  - All digits=0.
  - running=0, done=0, done_pulse=0.
  - clear has priority over every other input.
- FSM states and encoding: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- IDLE:
  - load → digits take the clamped preset on the next edge; state stays IDLE.
  - start with count≠0:00 → RUN.
  - start with count=0:00 → ignored.
- RUN:
  - tick=1 → decrement the count by one second.
  - pause=1 → PAUSE. If tick is also high that cycle, the decrement is still applied.
  - load and start are ignored.
- PAUSE:
  - start → RUN.
  - load → digits reload and state goes to IDLE.
  - tick is ignored.
  - If start and pause are both high, pause wins and the state stays PAUSE.
- DONE:
  - Digits held at 0:00; done=1.
  - load → reload and go to IDLE; done=0 on the same edge.
  - start, pause and tick are ignored.
- Decrement rule (BCD, each digit 4 bits):
  - units>0 → units−1.
  - Otherwise units=UNITS_MAX, and tens borrows: tens>0 → tens−1; otherwise tens=TENS_MAX and min−1.
  - A borrow past minutes cannot occur, because 0:00 is never decremented.
- Zero detect:
  - When a tick in RUN makes the count 0:00 (e.g. 0:01 → 0:00), state=DONE on that same edge.
  - done=1 and done_pulse=1 for exactly that one cycle.
  - running drops on that edge.
- Clamping on load:
  - Any preset digit above its MAX loads as MAX (e.g. tens=7 loads 5; units=12 loads 9).
- Latency:
  - All outputs are registered.
  - Effects appear one clock after the sampled inputs.
  - running, done and state are decoded from the registered state.
- Simultaneous load and start:
  - In IDLE: load is applied, start is ignored that cycle.
  - In PAUSE: pause-over-start and load-over-start priority applies; load wins.

Decomposition:
- Shared package holds:
  - State encoding constants: ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE.
  - Digit width constant DIGIT_W=4.
  - Default MAX values.
- One sub-module, bcd_down_digit, instantiated three times.
  - Inputs: clk, clear, en, ld, ld_val, max.
  - Outputs: q, borrow_out, where borrow_out = en & (q==0).
  - The controller chains borrow_out into the next digit's en.

Test Plan:
- Reset mid-run: load 1:30, start, 3 ticks, clear=0 → next edge digits 0:00, state=IDLE, running=0, done=0.
- Borrow chain: load 1:00, start, 1 tick → 0:59; load 0:10, start, 1 tick → 0:09.
- Zero reach: load 0:02, start, 2 ticks → 0:00, state=DONE, done_pulse high exactly 1 cycle, done stays 1; a further tick leaves 0:00.
- Pause/resume: load 0:20, start, 1 tick (0:19), pause with a coincident tick → 0:18 and PAUSE; 5 ticks → still 0:18; start → RUN, 1 tick → 0:17.
- Clamp and ignores: load min=12, tens=7, units=15 → 9:59; start in IDLE at 0:00 → stays IDLE; load during RUN → count unchanged.
- Priority: in PAUSE assert start+pause → stays PAUSE; in DONE assert load with 0:05 → IDLE with 0:05, done=0.

Source files
------------

// File: rtl/countdown_controller_pkg.sv
// Shared definitions for the M:SS countdown controller: state encoding,
// digit width, default digit limits and the preset clamp helper.
package countdown_controller_pkg;

   localparam int DIGIT_W       = 4;
   localparam int MIN_MAX_DEF   = 9;
   localparam int TENS_MAX_DEF  = 5;
   localparam int UNITS_MAX_DEF = 9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic logic [DIGIT_W-1:0] clamp_digit(
      input logic [DIGIT_W-1:0] val,
      input logic [DIGIT_W-1:0] max
   );
      return (val > max) ? max : val;
   endfunction

endpackage

// File: rtl/countdown_controller_digit.sv
// One BCD down-counting digit with clamped load; borrow_out asks the next
// more significant digit to step down when this digit wraps from 0 to max.
module bcd_down_digit
   import countdown_controller_pkg::*;
(
   input  logic               clk,
   input  logic               clear,
   input  logic               en,
   input  logic               ld,
   input  logic [DIGIT_W-1:0] ld_val,
   input  logic [DIGIT_W-1:0] max,
   output logic [DIGIT_W-1:0] q,
   output logic               borrow_out
);

   localparam logic [DIGIT_W-1:0] ONE = DIGIT_W'(1);

   logic [DIGIT_W-1:0] r_q;

   always_ff @(posedge clk) begin
      if (!clear) begin
         r_q <= '0;
      end else if (ld) begin
         r_q <= clamp_digit(ld_val, max);
      end else if (en) begin
         r_q <= (r_q == '0) ? max : (r_q - ONE);
      end
   end

   assign q          = r_q;
   assign borrow_out = en & (r_q == '0);

endmodule

// File: rtl/countdown_controller.sv
// Countdown sequencer for three BCD digits (M:SS): load, run on 1 Hz ticks,
// pause/resume, and a DONE state with a one-cycle entry pulse.
module countdown_controller
   import countdown_controller_pkg::*;
#(
   parameter int MIN_MAX   = MIN_MAX_DEF,
   parameter int TENS_MAX  = TENS_MAX_DEF,
   parameter int UNITS_MAX = UNITS_MAX_DEF
) (
   input  logic               clk,
   input  logic               clear,
   input  logic               tick,
   input  logic               load,
   input  logic               start,
   input  logic               pause,
   input  logic [DIGIT_W-1:0] preset_min,
   input  logic [DIGIT_W-1:0] preset_tens,
   input  logic [DIGIT_W-1:0] preset_units,
   output logic [DIGIT_W-1:0] q_min,
   output logic [DIGIT_W-1:0] q_tens,
   output logic [DIGIT_W-1:0] q_units,
   output logic               running,
   output logic               done,
   output logic               done_pulse,
   output logic [1:0]         state
);

   localparam logic [DIGIT_W-1:0] MIN_MAX_V   = DIGIT_W'(MIN_MAX);
   localparam logic [DIGIT_W-1:0] TENS_MAX_V  = DIGIT_W'(TENS_MAX);
   localparam logic [DIGIT_W-1:0] UNITS_MAX_V = DIGIT_W'(UNITS_MAX);
   localparam logic [DIGIT_W-1:0] ONE         = DIGIT_W'(1);

   state_t             r_state;
   state_t             w_next_state;
   logic               r_done_pulse;
   logic               w_ld;
   logic               w_dec;
   logic               w_count_zero;
   logic               w_dec_to_zero;
   logic               w_borrow_units;
   logic               w_borrow_tens;
   logic               w_borrow_min;
   logic [DIGIT_W-1:0] w_q_min;
   logic [DIGIT_W-1:0] w_q_tens;
   logic [DIGIT_W-1:0] w_q_units;

   // Units step on every accepted tick; each borrow ripples one digit up.
   assign w_dec = tick & (r_state == ST_RUN);

   bcd_down_digit u_units (
      .clk        (clk),
      .clear      (clear),
      .en         (w_dec),
      .ld         (w_ld),
      .ld_val     (preset_units),
      .max        (UNITS_MAX_V),
      .q          (w_q_units),
      .borrow_out (w_borrow_units)
   );

   bcd_down_digit u_tens (
      .clk        (clk),
      .clear      (clear),
      .en         (w_borrow_units),
      .ld         (w_ld),
      .ld_val     (preset_tens),
      .max        (TENS_MAX_V),
      .q          (w_q_tens),
      .borrow_out (w_borrow_tens)
   );

   bcd_down_digit u_min (
      .clk        (clk),
      .clear      (clear),
      .en         (w_borrow_tens),
      .ld         (w_ld),
      .ld_val     (preset_min),
      .max        (MIN_MAX_V),
      .q          (w_q_min),
      .borrow_out (w_borrow_min)
   );

   assign w_count_zero  = (w_q_min == '0) && (w_q_tens == '0) && (w_q_units == '0);
   assign w_dec_to_zero = w_dec && (w_q_min == '0) && (w_q_tens == '0) && (w_q_units == ONE);

   always_ff @(posedge clk) begin
      if (!clear) begin
         r_state      <= ST_IDLE;
         r_done_pulse <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_done_pulse <= (r_state == ST_RUN) && (w_next_state == ST_DONE);
      end
   end

   // Load beats start everywhere; in PAUSE, pause also beats start.
   always_comb begin
      w_next_state = r_state;
      w_ld         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (load) begin
               w_ld = 1'b1;
            end else if (start && !w_count_zero) begin
               w_next_state = ST_RUN;
            end
         end
         ST_RUN: begin
            // A borrow out of minutes means 0:00 was decremented; park in DONE.
            if (w_dec_to_zero || w_borrow_min) begin
               w_next_state = ST_DONE;
            end else if (pause) begin
               w_next_state = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (load) begin
               w_ld         = 1'b1;
               w_next_state = ST_IDLE;
            end else if (start && !pause) begin
               w_next_state = ST_RUN;
            end
         end
         ST_DONE: begin
            if (load) begin
               w_ld         = 1'b1;
               w_next_state = ST_IDLE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   assign q_min      = w_q_min;
   assign q_tens     = w_q_tens;
   assign q_units    = w_q_units;
   assign running    = (r_state == ST_RUN);
   assign done       = (r_state == ST_DONE);
   assign done_pulse = r_done_pulse;
   assign state      = r_state;

endmodule

// File: tb/tb_countdown_controller.sv
// Bench for countdown_controller: directed scenarios plus random stimulus,
// all checked against a seconds-based reference model.
module tb_countdown_controller;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;

   logic       clk = 1'b0;
   logic       clear, tick, load, start, pause;
   logic [3:0] preset_min, preset_tens, preset_units;
   logic [3:0] q_min, q_tens, q_units;
   logic       running, done, done_pulse;
   logic [1:0] state;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: count held as total seconds.
   int m_cnt   = 0;
   int m_state = M_IDLE;
   bit m_pulse = 1'b0;

   always #5 clk = ~clk;

   countdown_controller dut (
      .clk          (clk),
      .clear        (clear),
      .tick         (tick),
      .load         (load),
      .start        (start),
      .pause        (pause),
      .preset_min   (preset_min),
      .preset_tens  (preset_tens),
      .preset_units (preset_units),
      .q_min        (q_min),
      .q_tens       (q_tens),
      .q_units      (q_units),
      .running      (running),
      .done         (done),
      .done_pulse   (done_pulse),
      .state        (state)
   );

   wire [16:0] w_obs = {q_min, q_tens, q_units, state, running, done, done_pulse};

   function automatic int clamp(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   function automatic logic [16:0] model_vec();
      int mm = m_cnt / 60;
      int tt = (m_cnt % 60) / 10;
      int uu = m_cnt % 10;
      return {4'(mm), 4'(tt), 4'(uu), 2'(m_state),
              (m_state == M_RUN), (m_state == M_DONE), m_pulse};
   endfunction

   // Drive one cycle of inputs, advance the model at the edge, return at negedge.
   task automatic step(input logic c, input logic t, input logic l, input logic s,
                       input logic p, input int pm, input int pt, input int pu);
      int ld_secs;
      clear = c; tick = t; load = l; start = s; pause = p;
      preset_min = 4'(pm); preset_tens = 4'(pt); preset_units = 4'(pu);
      ld_secs = clamp(pm, 9) * 60 + clamp(pt, 5) * 10 + clamp(pu, 9);
      @(posedge clk);
      m_pulse = 1'b0;
      if (!c) begin
         m_cnt   = 0;
         m_state = M_IDLE;
      end else begin
         case (m_state)
            M_IDLE: begin
               if (l) m_cnt = ld_secs;
               else if (s && m_cnt != 0) m_state = M_RUN;
            end
            M_RUN: begin
               if (t) m_cnt = m_cnt - 1;
               if (t && m_cnt == 0) begin
                  m_state = M_DONE;
                  m_pulse = 1'b1;
               end else if (p) begin
                  m_state = M_PAUSE;
               end
            end
            M_PAUSE: begin
               if (l) begin
                  m_cnt   = ld_secs;
                  m_state = M_IDLE;
               end else if (s && !p) begin
                  m_state = M_RUN;
               end
            end
            default: begin
               if (l) begin
                  m_cnt   = ld_secs;
                  m_state = M_IDLE;
               end
            end
         endcase
      end
      @(negedge clk);
   endtask

   task automatic do_idle();                         step(1, 0, 0, 0, 0, 0, 0, 0); endtask
   task automatic do_load(input int m, t, u);        step(1, 0, 1, 0, 0, m, t, u); endtask
   task automatic do_start();                        step(1, 0, 0, 1, 0, 0, 0, 0); endtask
   task automatic do_tick();                         step(1, 1, 0, 0, 0, 0, 0, 0); endtask
   task automatic do_pause();                        step(1, 0, 0, 0, 1, 0, 0, 0); endtask

   task automatic test_reset();
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 1, 1, 0, 3, 3, 3);
      n_cmp++;
      if (w_obs !== 17'h0) begin
         n_err++;
         $display("FAIL reset_init: got %h expected %h", w_obs, 17'h0);
      end
      do_load(1, 3, 0);
      do_start();
      repeat (3) do_tick();
      n_cmp++;
      if (w_obs !== {12'h127, 2'd1, 3'b100}) begin
         n_err++;
         $display("FAIL run_before_reset: got %h expected %h", w_obs, {12'h127, 2'd1, 3'b100});
      end
      step(0, 1, 1, 1, 1, 5, 5, 5);
      n_cmp++;
      if (w_obs !== 17'h0) begin
         n_err++;
         $display("FAIL reset_mid_run: got %h expected %h", w_obs, 17'h0);
      end
   endtask

   task automatic test_borrow();
      do_load(1, 0, 0);
      do_start();
      do_tick();
      n_cmp++;
      if (w_obs !== {12'h059, 2'd1, 3'b100}) begin
         n_err++;
         $display("FAIL borrow_1_00: got %h expected %h", w_obs, {12'h059, 2'd1, 3'b100});
      end
      do_pause();
      do_load(0, 1, 0);
      n_cmp++;
      if (w_obs !== {12'h010, 2'd0, 3'b000}) begin
         n_err++;
         $display("FAIL pause_load: got %h expected %h", w_obs, {12'h010, 2'd0, 3'b000});
      end
      do_start();
      do_tick();
      n_cmp++;
      if (w_obs !== {12'h009, 2'd1, 3'b100}) begin
         n_err++;
         $display("FAIL borrow_0_10: got %h expected %h", w_obs, {12'h009, 2'd1, 3'b100});
      end
   endtask

   task automatic test_zero();
      do_pause();
      do_load(0, 0, 2);
      do_start();
      do_tick();
      do_tick();
      n_cmp++;
      if (w_obs !== {12'h000, 2'd3, 3'b011}) begin
         n_err++;
         $display("FAIL zero_entry: got %h expected %h", w_obs, {12'h000, 2'd3, 3'b011});
      end
      do_idle();
      n_cmp++;
      if (w_obs !== {12'h000, 2'd3, 3'b010}) begin
         n_err++;
         $display("FAIL done_pulse_width: got %h expected %h", w_obs, {12'h000, 2'd3, 3'b010});
      end
      do_tick();
      step(1, 1, 0, 1, 1, 0, 0, 0);
      n_cmp++;
      if (w_obs !== {12'h000, 2'd3, 3'b010}) begin
         n_err++;
         $display("FAIL done_hold: got %h expected %h", w_obs, {12'h000, 2'd3, 3'b010});
      end
   endtask

   task automatic test_pause_resume();
      do_load(0, 2, 0);
      n_cmp++;
      if (w_obs !== {12'h020, 2'd0, 3'b000}) begin
         n_err++;
         $display("FAIL done_reload: got %h expected %h", w_obs, {12'h020, 2'd0, 3'b000});
      end
      do_start();
      do_tick();
      step(1, 1, 0, 0, 1, 0, 0, 0);
      n_cmp++;
      if (w_obs !== {12'h018, 2'd2, 3'b000}) begin
         n_err++;
         $display("FAIL pause_with_tick: got %h expected %h", w_obs, {12'h018, 2'd2, 3'b000});
      end
      repeat (5) do_tick();
      n_cmp++;
      if (w_obs !== {12'h018, 2'd2, 3'b000}) begin
         n_err++;
         $display("FAIL pause_ignores_tick: got %h expected %h", w_obs, {12'h018, 2'd2, 3'b000});
      end
      do_start();
      do_tick();
      n_cmp++;
      if (w_obs !== {12'h017, 2'd1, 3'b100}) begin
         n_err++;
         $display("FAIL resume: got %h expected %h", w_obs, {12'h017, 2'd1, 3'b100});
      end
   endtask

   task automatic test_clamp_ignore();
      do_pause();
      do_load(12, 7, 15);
      n_cmp++;
      if (w_obs !== {12'h959, 2'd0, 3'b000}) begin
         n_err++;
         $display("FAIL clamp: got %h expected %h", w_obs, {12'h959, 2'd0, 3'b000});
      end
      do_load(0, 0, 0);
      do_start();
      n_cmp++;
      if (w_obs !== {12'h000, 2'd0, 3'b000}) begin
         n_err++;
         $display("FAIL start_at_zero: got %h expected %h", w_obs, {12'h000, 2'd0, 3'b000});
      end
      do_load(0, 0, 5);
      do_start();
      do_load(3, 3, 3);
      n_cmp++;
      if (w_obs !== {12'h005, 2'd1, 3'b100}) begin
         n_err++;
         $display("FAIL load_in_run: got %h expected %h", w_obs, {12'h005, 2'd1, 3'b100});
      end
      do_pause();
      step(1, 0, 1, 1, 0, 0, 4, 0);
      n_cmp++;
      if (w_obs !== {12'h040, 2'd0, 3'b000}) begin
         n_err++;
         $display("FAIL pause_load_start: got %h expected %h", w_obs, {12'h040, 2'd0, 3'b000});
      end
      step(1, 0, 1, 1, 0, 0, 3, 0);
      n_cmp++;
      if (w_obs !== {12'h030, 2'd0, 3'b000}) begin
         n_err++;
         $display("FAIL idle_load_start: got %h expected %h", w_obs, {12'h030, 2'd0, 3'b000});
      end
   endtask

   task automatic test_priority();
      do_start();
      do_pause();
      step(1, 0, 0, 1, 1, 0, 0, 0);
      n_cmp++;
      if (w_obs !== {12'h030, 2'd2, 3'b000}) begin
         n_err++;
         $display("FAIL pause_over_start: got %h expected %h", w_obs, {12'h030, 2'd2, 3'b000});
      end
      do_start();
      repeat (30) do_tick();
      n_cmp++;
      if (w_obs !== {12'h000, 2'd3, 3'b011}) begin
         n_err++;
         $display("FAIL count_30s: got %h expected %h", w_obs, {12'h000, 2'd3, 3'b011});
      end
      do_load(0, 0, 5);
      n_cmp++;
      if (w_obs !== {12'h005, 2'd0, 3'b000}) begin
         n_err++;
         $display("FAIL done_load: got %h expected %h", w_obs, {12'h005, 2'd0, 3'b000});
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         logic c, t, l, s, p;
         int   pm, pt, pu;
         c  = ($urandom_range(0, 63) != 0);
         t  = ($urandom_range(0, 2) == 0);
         l  = ($urandom_range(0, 9) == 0);
         s  = ($urandom_range(0, 3) == 0);
         p  = ($urandom_range(0, 7) == 0);
         pm = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 0;
         pt = $urandom_range(0, 7);
         pu = $urandom_range(0, 15);
         step(c, t, l, s, p, pm, pt, pu);
         n_cmp++;
         if (w_obs !== model_vec()) begin
            n_err++;
            $display("FAIL random[%0d]: got %h expected %h", i, w_obs, model_vec());
         end
      end
   endtask

   initial begin
      clear = 1'b0; tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
      preset_min = '0; preset_tens = '0; preset_units = '0;
      @(negedge clk);
      test_reset();
      test_borrow();
      test_zero();
      test_pause_resume();
      test_clamp_ignore();
      test_priority();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
